// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the 8x8 systolic-array sequencer.
//   - default widths (lane data, array dimension, k index)
//   - FSM state encoding
//   - phase lengths for the flush and drain windows
//   - uniform PE mask constants
package sa_pkg;

    localparam int SA_N   = 32;
    localparam int SA_DIM = 8;
    localparam int SA_KW  = 8;

    // Skewed data needs 2*(DIM-1)+2 cycles after the last read to reach PE(7,7).
    localparam int FLUSH_CYCLES = 16;
    localparam int DRAIN_CYCLES = 8;

    localparam logic [SA_DIM*SA_DIM-1:0] MASK_ONES = '1;
    localparam logic [SA_DIM*SA_DIM-1:0] MASK_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        LATCH,
        DRAIN,
        DONE
    } sa_state_e;

endpackage

// File: rtl/sa_skew_buffer.sv
// sa_skew_buffer: triangular delay line feeding one edge of the array.
//   Lane i is delayed by 1+i register stages, so a vector presented in one
//   cycle arrives diagonally across the array edge.
// Ports:
//   clk     - clock
//   clr     - synchronous clear of every stage
//   in_vec  - DIM lanes of N bits, lane i = bits i*N +: N
//   out_vec - delayed lanes, same packing
module sa_skew_buffer #(
    parameter int N   = 32,
    parameter int DIM = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N*DIM-1:0] in_vec,
    output logic [N*DIM-1:0] out_vec
);

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic [i:0][N-1:0] sr_q;
        logic [i:0][N-1:0] sr_d;

        always_comb begin
            sr_d[0] = in_vec[i*N +: N];
            for (int s = 1; s <= i; s++) begin
                sr_d[s] = sr_q[s-1];
            end
        end

        always_ff @(posedge clk) begin
            if (clr) sr_q <= '0;
            else     sr_q <= sr_d;
        end

        assign out_vec[i*N +: N] = sr_q[i];
    end

endmodule

// File: rtl/sa8_sequencer.sv
// sa8_sequencer: sequences one C = A(8xK) * B(Kx8) job on an 8x8
// output-stationary systolic array.
// Ports:
//   clk, clr            - clock, synchronous active-high reset
//   start, k_len        - job request (sampled in IDLE only) and inner dimension
//   busy, done          - job in flight / one-cycle completion pulse
//   op_rd_en/_addr      - operand buffer read; a_vec/b_vec return next cycle
//   sa_a, sa_b          - skewed operand lanes to the array edges
//   pe_clr/read/write   - uniform PE control masks
//   sa_c                - bottom B outputs of the array
//   res_valid/row/data  - one registered C row per cycle, row 7 first
module sa8_sequencer
    import sa_pkg::*;
#(
    parameter int N   = SA_N,
    parameter int DIM = SA_DIM,
    parameter int KW  = SA_KW
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    output logic               busy,
    output logic               done,
    output logic               op_rd_en,
    output logic [KW-1:0]      op_rd_addr,
    input  logic [N*DIM-1:0]   a_vec,
    input  logic [N*DIM-1:0]   b_vec,
    output logic [N*DIM-1:0]   sa_a,
    output logic [N*DIM-1:0]   sa_b,
    output logic [DIM*DIM-1:0] pe_clr,
    output logic [DIM*DIM-1:0] pe_read,
    output logic [DIM*DIM-1:0] pe_write,
    input  logic [N*DIM-1:0]   sa_c,
    output logic               res_valid,
    output logic [2:0]         res_row,
    output logic [N*DIM-1:0]   res_data
);

    sa_state_e        state_q, state_d;
    logic [KW-1:0]    k_len_q, k_len_d;
    logic [KW-1:0]    k_cnt_q, k_cnt_d;
    logic [4:0]       ph_q, ph_d;
    logic             rd_vld_q, rd_vld_d;
    logic             res_valid_q, res_valid_d;
    logic [2:0]       res_row_q, res_row_d;
    logic [N*DIM-1:0] res_data_q, res_data_d;
    logic [N*DIM-1:0] a_in, b_in;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        k_cnt_d     = k_cnt_q;
        ph_d        = ph_q;
        busy        = 1'b1;
        done        = 1'b0;
        op_rd_en    = 1'b0;
        op_rd_addr  = '0;
        pe_clr      = MASK_ZERO;
        pe_read     = MASK_ZERO;
        pe_write    = MASK_ZERO;
        res_valid_d = 1'b0;
        res_row_d   = res_row_q;
        res_data_d  = res_data_q;

        case (state_q)
            IDLE: begin
                busy   = 1'b0;
                pe_clr = MASK_ONES;
                if (start) begin
                    k_len_d = k_len;
                    k_cnt_d = '0;
                    ph_d    = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                pe_clr  = MASK_ONES;
                k_cnt_d = '0;
                ph_d    = '0;
                // K=0 still runs the flush window so job latency is always K+27.
                state_d = (k_len_q != '0) ? FEED : FLUSH;
            end
            FEED: begin
                op_rd_en   = 1'b1;
                op_rd_addr = k_cnt_q;
                if (k_cnt_q == k_len_q - 1'b1) begin
                    ph_d    = '0;
                    state_d = FLUSH;
                end else begin
                    k_cnt_d = k_cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (ph_q == 5'(FLUSH_CYCLES - 1)) begin
                    ph_d    = '0;
                    state_d = LATCH;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            LATCH: begin
                pe_read = MASK_ONES;
                ph_d    = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                // Bottom row leaves first, so the row index counts down.
                pe_write    = MASK_ONES;
                res_valid_d = 1'b1;
                res_row_d   = 3'(DRAIN_CYCLES - 1) - ph_q[2:0];
                res_data_d  = sa_c;
                if (ph_q == 5'(DRAIN_CYCLES - 1)) begin
                    ph_d    = '0;
                    state_d = DONE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Buffer data is only meaningful the cycle after a read; otherwise feed
    // zeros so the skew lines carry zero outside the valid wavefront.
    assign rd_vld_d = op_rd_en;
    assign a_in     = rd_vld_q ? a_vec : '0;
    assign b_in     = rd_vld_q ? b_vec : '0;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            ph_q        <= '0;
            rd_vld_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            k_cnt_q     <= k_cnt_d;
            ph_q        <= ph_d;
            rd_vld_q    <= rd_vld_d;
            res_valid_q <= res_valid_d;
            res_row_q   <= res_row_d;
            res_data_q  <= res_data_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_row   = res_row_q;
    assign res_data  = res_data_q;

    sa_skew_buffer #(.N(N), .DIM(DIM)) u_skew_a (
        .clk     (clk),
        .clr     (clr),
        .in_vec  (a_in),
        .out_vec (sa_a)
    );

    sa_skew_buffer #(.N(N), .DIM(DIM)) u_skew_b (
        .clk     (clk),
        .clr     (clr),
        .in_vec  (b_in),
        .out_vec (sa_b)
    );

endmodule
